l2_mem_write_buffer: RTL
========================

// Module: l2_mem_write_buffer
// PURPOSE
// - Posted write buffer between the L2 cache's memory port and main memory.
// - L2 evictions of dirty blocks are accepted in 1 cycle and drained to memory in the background.
// - L2 block reads are answered from the buffer when the address matches a pending entry; otherwise they are forwarded to memory.
// - Reads are prioritised over drains.
// PARAMETERS
// DEPTH  4    number of 128-bit write entries (power of 2, >=2)
// AW     28   block address width (word address bits [29:2])
// DW     128  block data width
// PORTS
// clk         in   1     clock; all state changes on posedge
// proc_reset  in   1     synchronous, active-high reset
// l2_read     in   1     L2 block read request; held until l2_ready seen
// l2_write    in   1     L2 block write request; held until l2_ready seen
// l2_addr     in   AW    request block address
// l2_wdata    in   DW    write data
// l2_rdata    out  DW    read data; valid while l2_ready=1 for a read
// l2_ready    out  1     one-cycle completion pulse to L2
// mem_read    out  1     memory read request; held until mem_ready sampled
// mem_write   out  1     memory write request; held until mem_ready sampled
// mem_addr    out  AW    memory block address
// mem_wdata   out  DW    memory write data
// mem_rdata   in   DW    memory read data; valid with mem_ready
// mem_ready   in   1     memory completion pulse
// buf_empty   out  1     1 when count==0 and no memory transaction is active
// BEHAVIOUR
// - Outputs, reset and protocol:
//   - All outputs registered.
//   - On proc_reset: l2_ready=0, l2_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, buf_empty=1, count/rd_ptr/wr_ptr=0, both FSMs idle.
//   - Reset mid-transaction abandons it; buffered data is lost.
//   - A request is new only in a cycle with l2_ready=0 and the upstream FSM in U_IDLE. The cycle in which l2_ready=1 never starts a request.
//   - l2_read and l2_write together: read wins and the write is ignored.
// - Upstream FSM:
//   - U_IDLE, write, count<DEPTH: if a valid entry other than the in-flight head has the same address, overwrite its data (merge). Else store at wr_ptr, wr_ptr++, count++. -> U_ACK.
//   - U_IDLE, write, count==DEPTH: stay in U_IDLE. Accept on the first cycle count<DEPTH.
//   - U_IDLE, read hit (any valid entry matches, including the in-flight head): l2_rdata <= newest matching entry. -> U_ACK.
//   - U_IDLE, read miss: set rd_pend. -> U_WAIT.
//   - U_ACK: l2_ready=1 for exactly 1 cycle. -> U_IDLE.
//   - U_WAIT: when the memory read completes, l2_rdata <= mem_rdata and l2_ready=1 next cycle. -> U_ACK.
//   - Latency, request seen in cycle N: write (not full) or read hit -> l2_ready in N+1.
//   - Latency, read miss: mem_read in N+1 at the earliest; l2_ready 1 cycle after mem_ready.
// - Memory FSM:
//   - M_IDLE, rd_pend: mem_read<=1, mem_addr<=l2_addr. -> M_RD.
//   - M_IDLE, else if count>0: mem_write<=1, mem_addr/mem_wdata<=head entry. -> M_WR.
//   - M_RD, on mem_ready: mem_read<=0, capture mem_rdata, clear rd_pend. -> M_IDLE.
//   - M_WR, on mem_ready: mem_write<=0, rd_ptr++, count--. -> M_IDLE.
//   - An in-flight drain is never aborted. A read miss waits for it to finish.
//   - mem_read and mem_write are never 1 together. Address and data stay stable while the request is held.
// - Pointers and count:
//   - rd_ptr and wr_ptr wrap modulo DEPTH.
//   - Enqueue and pop in the same cycle: count unchanged, both pointers advance.
//   - The head in M_WR is frozen: no merge into it, and a same-address write allocates a new entry.
//   - Newest match = the matching entry closest behind wr_ptr.
// TESTING
// - Reset, then write A=0x10 D0 -> l2_ready one cycle later. Then mem_write with mem_addr=0x10, mem_wdata=D0. After mem_ready, buf_empty=1.
// - Hold mem_ready=0. 4 writes to 0x1..0x4 each ack in 1 cycle. A 5th write to 0x5 gets no l2_ready until the first mem_ready, then is acked.
// - Write 0x20=D1, then read 0x20 while the drain is stalled -> l2_rdata=D1 one cycle later, no mem_read.
// - Write 0x30=D1, then write 0x30=D2 before it drains -> count stays 1 if not yet in flight; memory sees only D2. If already in flight, memory sees D1 then D2.
// - Read miss 0x40 with 2 pending writes, first in M_WR -> mem_read issued right after that mem_ready, before the second write. l2_rdata=mem_rdata.
// - Assert proc_reset during M_WR -> next cycle mem_write=0, buf_empty=1, l2_ready=0.

Source files
------------

// File: rtl/l2_mem_write_buffer.sv
// l2_mem_write_buffer: posted write buffer between the L2 memory port and main memory, with read forwarding
module l2_mem_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW = 28,
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          proc_reset,
  input  logic          l2_read,
  input  logic          l2_write,
  input  logic [AW-1:0] l2_addr,
  input  logic [DW-1:0] l2_wdata,
  output logic [DW-1:0] l2_rdata,
  output logic          l2_ready,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          buf_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  typedef enum logic [1:0] {U_IDLE, U_ACK, U_WAIT} u_t;
  typedef enum logic [1:0] {M_IDLE, M_RD, M_WR} m_t;
  u_t ustate, u_nxt;
  m_t mstate, m_nxt;
  logic [AW-1:0] ea [DEPTH];
  logic [DW-1:0] ed [DEPTH];
  logic [DEPTH-1:0] ev;
  logic [PW-1:0] rd_ptr, wr_ptr, idx, r_idx, w_idx;
  logic [PW:0] count, count_nxt;
  logic rd_pend, req, rd_req, wr_req, r_hit, w_hit, head_lock, wr_ok, merge, enq, miss, pop, rd_done, start_rd, start_wr;
  // head is locked once it is in flight or about to launch this cycle, so a merge never races the drain
  assign head_lock = (mstate == M_WR) || (mstate == M_IDLE && !rd_pend && count != '0);
  always_comb begin
    r_hit = 1'b0;
    w_hit = 1'b0;
    r_idx = '0;
    w_idx = '0;
    idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      idx = wr_ptr - PW'(k + 1);
      if (ev[idx] && ea[idx] == l2_addr) begin
        r_hit = 1'b1;
        r_idx = idx;
        if (!(head_lock && idx == rd_ptr)) begin
          w_hit = 1'b1;
          w_idx = idx;
        end
      end
    end
  end
  always_comb begin
    req = ustate == U_IDLE && !l2_ready;
    rd_req = req && l2_read;
    wr_req = req && l2_write && !l2_read;
    wr_ok = wr_req && count < FULL;
    merge = wr_ok && w_hit;
    enq = wr_ok && !w_hit;
    miss = rd_req && !r_hit;
    pop = mstate == M_WR && mem_ready;
    rd_done = mstate == M_RD && mem_ready;
    start_rd = mstate == M_IDLE && (rd_pend || miss);
    start_wr = mstate == M_IDLE && !start_rd && count != '0;
    u_nxt = ustate;
    case (ustate)
      U_IDLE: u_nxt = (wr_ok || (rd_req && r_hit)) ? U_ACK : miss ? U_WAIT : U_IDLE;
      U_ACK:  u_nxt = U_IDLE;
      U_WAIT: u_nxt = rd_done ? U_ACK : U_WAIT;
      default: u_nxt = U_IDLE;
    endcase
    m_nxt = mstate == M_IDLE ? (start_rd ? M_RD : start_wr ? M_WR : M_IDLE)
          : mem_ready ? M_IDLE : mstate;
    count_nxt = count + (PW+1)'(enq) - (PW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      ustate <= U_IDLE;
      mstate <= M_IDLE;
      l2_ready <= 1'b0;
      l2_rdata <= '0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      buf_empty <= 1'b1;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      ev <= '0;
      rd_pend <= 1'b0;
    end else begin
      ustate <= u_nxt;
      mstate <= m_nxt;
      count <= count_nxt;
      l2_ready <= u_nxt == U_ACK;
      buf_empty <= count_nxt == '0 && m_nxt == M_IDLE;
      rd_pend <= miss || (rd_pend && !rd_done);
      if (rd_req && r_hit) l2_rdata <= ed[r_idx];
      if (rd_done) l2_rdata <= mem_rdata;
      if (merge) ed[w_idx] <= l2_wdata;
      if (enq) begin
        ea[wr_ptr] <= l2_addr;
        ed[wr_ptr] <= l2_wdata;
        ev[wr_ptr] <= 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        ev[rd_ptr] <= 1'b0;
        rd_ptr <= rd_ptr + 1'b1;
        mem_write <= 1'b0;
      end
      if (rd_done) mem_read <= 1'b0;
      if (start_rd) begin
        mem_read <= 1'b1;
        mem_addr <= l2_addr;
      end else if (start_wr) begin
        mem_write <= 1'b1;
        mem_addr <= ea[rd_ptr];
        mem_wdata <= ed[rd_ptr];
      end
    end
  end
endmodule
